fifo_read_ctrl: RTL

//  Read-side pointer/flag controller of the async FIFO; the read-clock counterpart of the write controller.

---
 rtl/fifo_pkg.sv | 22 ++
 rtl/fifo_sync.sv | 32 +++
 rtl/fifo_read_ctrl.sv | 81 ++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared pointer helpers for both sides of the async FIFO.
// Functions work on 32-bit vectors; callers truncate to their pointer width.
package fifo_pkg;

  localparam int MAX_PTR_W = 32;

  function automatic logic [MAX_PTR_W-1:0] b2g(input logic [MAX_PTR_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Upper bits are zero for narrower pointers, so the prefix XOR is width-agnostic.
  function automatic logic [MAX_PTR_W-1:0] g2b(input logic [MAX_PTR_W-1:0] g);
    logic [MAX_PTR_W-1:0] b;
    b = '0;
    b[MAX_PTR_W-1] = g[MAX_PTR_W-1];
    for (int i = MAX_PTR_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/fifo_sync.sv
// Multi-flop synchronizer for Gray pointers crossing into this clock domain.
module fifo_sync #(
  parameter int WIDTH       = 5,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             srst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage_reg [SYNC_STAGES];

  generate
    for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_stage
      if (gi == 0) begin : g_first
        always_ff @(posedge clk) begin
          if (srst) stage_reg[gi] <= '0;
          else      stage_reg[gi] <= d;
        end
      end else begin : g_rest
        always_ff @(posedge clk) begin
          if (srst) stage_reg[gi] <= '0;
          else      stage_reg[gi] <= stage_reg[gi-1];
        end
      end
    end
  endgenerate

  assign q = stage_reg[SYNC_STAGES-1];

endmodule

// File: rtl/fifo_read_ctrl.sv
// Read-side pointer and flag controller of the async FIFO.
// Empty is computed from the post-read pointer so it is never optimistic.
module fifo_read_ctrl
  import fifo_pkg::*;
#(
  parameter int DEPTH       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int AE_THRESH   = 2,
  localparam int ADDR_W     = $clog2(DEPTH),
  localparam int PTR_W      = ADDR_W + 1
) (
  input  logic              rclk,
  input  logic              rrst,
  input  logic              rden,
  input  logic [PTR_W-1:0]  wrptr,
  output logic [PTR_W-1:0]  rdptr,
  output logic [ADDR_W-1:0] raddr,
  output logic              rd_empty,
  output logic              rd_almost_empty,
  output logic [PTR_W-1:0]  rd_count,
  output logic              rd_underflow
);

  logic [PTR_W-1:0] rbin_reg;
  logic [PTR_W-1:0] rdptr_reg;
  logic             rd_empty_reg;
  logic             rd_almost_empty_reg;
  logic [PTR_W-1:0] rd_count_reg;
  logic             rd_underflow_reg;

  logic [PTR_W-1:0] q2_wptr;
  logic [PTR_W-1:0] wbin_s;
  logic             rd_accept;
  logic [PTR_W-1:0] rbin_next;
  logic [PTR_W-1:0] rgray_next;
  logic [PTR_W-1:0] rd_count_next;

  fifo_sync #(
    .WIDTH      (PTR_W),
    .SYNC_STAGES(SYNC_STAGES)
  ) u_wptr_sync (
    .clk (rclk),
    .srst(rrst),
    .d   (wrptr),
    .q   (q2_wptr)
  );

  always_comb begin
    wbin_s        = PTR_W'(g2b(MAX_PTR_W'(q2_wptr)));
    rd_accept     = rden & ~rd_empty_reg;
    rbin_next     = rbin_reg + {{(PTR_W-1){1'b0}}, rd_accept};
    rgray_next    = PTR_W'(b2g(MAX_PTR_W'(rbin_next)));
    rd_count_next = wbin_s - rbin_next;
  end

  always_ff @(posedge rclk) begin
    if (rrst) begin
      rbin_reg            <= '0;
      rdptr_reg           <= '0;
      rd_empty_reg        <= 1'b1;
      rd_almost_empty_reg <= 1'b1;
      rd_count_reg        <= '0;
      rd_underflow_reg    <= 1'b0;
    end else begin
      rbin_reg            <= rbin_next;
      rdptr_reg           <= rgray_next;
      rd_empty_reg        <= (rgray_next == q2_wptr);
      rd_almost_empty_reg <= (rd_count_next <= PTR_W'(AE_THRESH));
      rd_count_reg        <= rd_count_next;
      rd_underflow_reg    <= rd_underflow_reg | (rden & rd_empty_reg);
    end
  end

  assign rdptr           = rdptr_reg;
  assign raddr           = rbin_reg[ADDR_W-1:0];
  assign rd_empty        = rd_empty_reg;
  assign rd_almost_empty = rd_almost_empty_reg;
  assign rd_count        = rd_count_reg;
  assign rd_underflow    = rd_underflow_reg;

endmodule
